n2tdmux4way16_buf: RTL and testbench
====================================

# n2tdmux4way16_buf

Registered 4-way, 16-bit demultiplexer with a valid/ready handshake on both sides. It is the distribution counterpart of our word multiplexers. A single input word stream is routed by a 2-bit select into one of four independent one-entry output buffers, and each buffer drains through its own handshake. It sits between a single producer, such as the CPU output path, and up to four consumers (memory-mapped sinks) that may stall independently.

## Interface
Parameters:
- WIDTH, 16, data word width in bits
- CNT_W, 16, width of the delivered-word counter

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous flush of all channel buffers
- in_valid  input  1  producer presents a word
- in_ready  output  1  block can accept the presented word
- in_data  input  WIDTH  word to route
- in_sel  input  2  destination channel, 0..3
- out_valid  output  4  bit k: channel k buffer holds a word
- out_ready  input  4  bit k: consumer k takes the word
- out_data  output  4*WIDTH  channel k data on bits [k*WIDTH +: WIDTH]
- word_cnt  output  CNT_W  total words delivered on all outputs

## Operation
- Each channel k is a two-state FSM:
  - EMPTY: out_valid[k]=0.
  - FULL: out_valid[k]=1, and out_data[k] holds the stored word.
- Accept condition: acc = in_valid & in_ready.
- in_ready = ~clr & (~out_valid[in_sel] | out_ready[in_sel]).
  - This is combinational from in_sel, out_valid, out_ready and clr.
  - in_ready depends only on the selected channel. A full, stalled channel never blocks words bound for another channel.
- Drain of channel k: dk = out_valid[k] & out_ready[k].
- Channel k next state:
  - clr: EMPTY. The data register is unchanged.
  - else acc & in_sel==k: FULL, and the data register loads in_data. This applies whether the prior state was EMPTY, or FULL with dk (pass-through refill).
  - else dk: EMPTY. The data register holds its value.
  - else: unchanged.
- Non-selected channels never load data, regardless of in_data.
- out_data for an EMPTY channel shows the last stored word (0 after reset). Consumers ignore it.
- word_cnt increments by popcount(d0..d3) each cycle, so up to +4 per cycle.
  - It wraps modulo 2^CNT_W.
  - clr does not reset it.
  - Drains in the same cycle as clr still count, because out_valid was 1 and the consumer took the word.
- in_sel is sampled only when in_valid=1. The producer holds in_data and in_sel stable while in_valid=1 and in_ready=0.

## Timing
- Reset (rst_n=0, asynchronous):
  - All channels EMPTY, out_valid=4'b0000.
  - out_data all zero, word_cnt=0.
  - in_ready=1 once rst_n=1 and clr=0.
- Latency is 1 cycle. A word accepted at edge N has out_valid[k]=1 from edge N.
- Throughput is one word per cycle when the consumer holds out_ready[k]=1 continuously, including back-to-back words to the same channel.
- Reset asserted mid-transfer discards all buffered words immediately. It does not wait for a clock edge.
- When clr and in_valid are both high, in_ready=0 and no word is accepted. The producer must retry.
- Four simultaneous drains in one cycle make word_cnt +4.

## Test plan
- Reset then routing: rst_n low, release, send 0x1111/sel0, 0x2222/sel1, 0x3333/sel2, 0x4444/sel3 with all out_ready=0.
  - out_valid=4'b1111, and each out_data[k] matches its word.
  - in_ready=0 for any sel after that.
  - word_cnt=0.
- Stall isolation: channel 2 full with out_ready[2]=0, then send 0xBEEF to sel1.
  - Accepted; out_valid[1]=1 next cycle.
  - in_ready=0 while sel=2.
  - Channel 2 data stays unchanged.
- Streaming pass-through: 8 consecutive words 0x0001..0x0008 to sel3 with out_ready[3]=1.
  - in_ready=1 every cycle.
  - Outputs appear one cycle later, in order.
  - word_cnt=8 after the last drain.
- Simultaneous drain and flush: all four channels full, assert out_ready=4'b1111 and clr=1 in one cycle, with in_valid=1.
  - Next cycle: out_valid=0 and word_cnt +4.
  - The input word is not accepted (in_ready=0).
- Counter wrap: preload with 0xFFFE deliveries (or force), then deliver 3 words.
  - word_cnt=0x0001.
- Async reset mid-operation: two channels full, pulse rst_n low between edges.
  - out_valid=0, out_data=0 and word_cnt=0 immediately, before the next edge.

Source files
------------

// File: rtl/n2tdmux4way16_buf.sv
// Registered 1-to-4 word demultiplexer: each destination owns a one-entry
// buffer with its own valid/ready drain, plus a running count of delivered words.
module n2tdmux4way16_buf #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]   word_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic             acc;
  logic [3:0]       valid_vec;
  logic [3:0]       drain;
  logic [2:0]       drain_cnt;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Only the addressed channel gates the producer, so a stalled sink cannot
  // hold up traffic bound elsewhere.
  assign in_ready = ~clr & (~valid_vec[in_sel] | out_ready[in_sel]);
  assign acc      = in_valid & in_ready;
  assign drain    = valid_vec & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      state_t           state_reg;
      state_t           state_next;
      logic [WIDTH-1:0] data_reg;
      logic [WIDTH-1:0] data_next;
      logic             load;

      assign load = acc & (in_sel == 2'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= EMPTY;
          data_reg  <= '0;
        end else begin
          state_reg <= state_next;
          data_reg  <= data_next;
        end
      end

      // A load wins over a drain so a full channel can refill in the same cycle.
      always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        if (clr) begin
          state_next = EMPTY;
        end else if (load) begin
          state_next = FULL;
          data_next  = in_data;
        end else if (drain[gi]) begin
          state_next = EMPTY;
        end
      end

      assign valid_vec[gi]                = (state_reg == FULL);
      assign out_data[gi*WIDTH +: WIDTH] = data_reg;
    end
  endgenerate

  assign out_valid = valid_vec;

  always_comb begin
    drain_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      drain_cnt = drain_cnt + 3'(drain[i]);
    end
  end

  // Drains coinciding with clr still count: the consumer did take the word.
  assign cnt_next = cnt_reg + CNT_W'(drain_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign word_cnt = cnt_reg;

endmodule

// File: tb/tb_n2tdmux4way16_buf.sv
// Self-checking bench for n2tdmux4way16_buf: directed vector table, streaming,
// random traffic against a buffer-level reference model, async reset and counter wrap.
module tb_n2tdmux4way16_buf;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [63:0] out_data;
  logic [15:0] word_cnt;

  n2tdmux4way16_buf #(.WIDTH(16), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: four one-word mailboxes and a delivery tally.
  bit          m_full [4];
  logic [15:0] m_data [4];
  logic [15:0] m_cnt;
  logic        last_ir;

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [3:0]  rdy;
    logic        clr;
    logic        exp_ir;
    logic [3:0]  exp_ov;
    logic [63:0] exp_od;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 0;
      m_data[k] = '0;
    end
    m_cnt = '0;
  endtask

  function automatic logic [3:0] model_ov();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = m_full[k];
    return r;
  endfunction

  function automatic logic [63:0] model_od();
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = m_data[k];
    return r;
  endfunction

  // One clock: drive at posedge+1, check in_ready before the edge, outputs after.
  task automatic cycle(input logic v, input logic [1:0] sel, input logic [15:0] d,
                       input logic [3:0] rdy, input logic c, input bit verbose);
    bit exp_ir;
    bit accepted;
    int ndrain;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
    clr       = c;
    #3;
    exp_ir  = !c && (!m_full[sel] || rdy[sel]);
    last_ir = in_ready;
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    accepted = v && exp_ir;
    ndrain = 0;
    for (int k = 0; k < 4; k++) begin
      bit took;
      took = m_full[k] && rdy[k];
      if (took) ndrain++;
      if (c) m_full[k] = 0;
      else if (accepted && sel == 2'(k)) begin
        m_full[k] = 1;
        m_data[k] = d;
      end else if (took) m_full[k] = 0;
    end
    m_cnt = m_cnt + 16'(ndrain);
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(model_ov()));
    chk("out_data", out_data, model_od());
    chk("word_cnt", 64'(word_cnt), 64'(m_cnt));
    if (verbose)
      $display("txn v=%0d sel=%0d data=%h rdy=%b clr=%0d acc=%0d -> out_valid=%b word_cnt=%0d",
               v, sel, d, rdy, c, accepted, out_valid, word_cnt);
  endtask

  initial begin
    logic        h_v;
    logic [1:0]  h_sel;
    logic [15:0] h_data;
    logic [15:0] cnt0;
    int          guard;

    vecs[0]  = '{1'b1, 2'd0, 16'h1111, 4'h0, 1'b0, 1'b1, 4'b0001, 64'h0000_0000_0000_1111, 16'd0};
    vecs[1]  = '{1'b1, 2'd1, 16'h2222, 4'h0, 1'b0, 1'b1, 4'b0011, 64'h0000_0000_2222_1111, 16'd0};
    vecs[2]  = '{1'b1, 2'd2, 16'h3333, 4'h0, 1'b0, 1'b1, 4'b0111, 64'h0000_3333_2222_1111, 16'd0};
    vecs[3]  = '{1'b1, 2'd3, 16'h4444, 4'h0, 1'b0, 1'b1, 4'b1111, 64'h4444_3333_2222_1111, 16'd0};
    vecs[4]  = '{1'b1, 2'd0, 16'h5555, 4'h0, 1'b0, 1'b0, 4'b1111, 64'h4444_3333_2222_1111, 16'd0};
    vecs[5]  = '{1'b1, 2'd3, 16'h6666, 4'h0, 1'b0, 1'b0, 4'b1111, 64'h4444_3333_2222_1111, 16'd0};
    vecs[6]  = '{1'b0, 2'd1, 16'h0000, 4'b0010, 1'b0, 1'b1, 4'b1101, 64'h4444_3333_2222_1111, 16'd1};
    vecs[7]  = '{1'b1, 2'd1, 16'hBEEF, 4'h0, 1'b0, 1'b1, 4'b1111, 64'h4444_3333_BEEF_1111, 16'd1};
    vecs[8]  = '{1'b1, 2'd2, 16'hDEAD, 4'h0, 1'b0, 1'b0, 4'b1111, 64'h4444_3333_BEEF_1111, 16'd1};
    vecs[9]  = '{1'b1, 2'd0, 16'h7777, 4'hF, 1'b1, 1'b0, 4'b0000, 64'h4444_3333_BEEF_1111, 16'd5};
    vecs[10] = '{1'b0, 2'd0, 16'h0000, 4'h0, 1'b0, 1'b1, 4'b0000, 64'h4444_3333_BEEF_1111, 16'd5};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_out_data", out_data, 64'h0);
    chk("reset_word_cnt", 64'(word_cnt), 64'h0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1;

    // Routing, stall isolation, simultaneous drain and flush.
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].rdy, vecs[i].clr, 1'b1);
      chk($sformatf("vec%0d_in_ready", i), 64'(last_ir), 64'(vecs[i].exp_ir));
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
      chk($sformatf("vec%0d_word_cnt", i), 64'(word_cnt), 64'(vecs[i].exp_cnt));
    end

    // Back-to-back streaming into channel 3 with its consumer always ready.
    cnt0 = word_cnt;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 2'd3, 16'(i), 4'b1000, 1'b0, 1'b1);
      chk("stream_in_ready", 64'(last_ir), 64'h1);
      chk("stream_valid3", 64'(out_valid[3]), 64'h1);
      chk("stream_data3", 64'(out_data[63:48]), 64'(i));
    end
    cycle(1'b0, 2'd3, 16'h0, 4'b1000, 1'b0, 1'b1);
    chk("stream_cnt", 64'(word_cnt), 64'(16'(cnt0 + 16'd8)));

    // Random traffic; the producer holds its word while stalled.
    h_v = 0; h_sel = 0; h_data = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(h_v && !last_ir)) begin
        h_v    = ($urandom_range(0, 3) != 0);
        h_sel  = 2'($urandom_range(0, 3));
        h_data = 16'($urandom);
      end
      cycle(h_v, h_sel, h_data, 4'($urandom), ($urandom_range(0, 15) == 0), 1'b0);
    end

    // Asynchronous reset between edges with two channels holding data.
    cycle(1'b0, 2'd0, 16'h0, 4'h0, 1'b1, 1'b1);
    cycle(1'b1, 2'd0, 16'hA5A5, 4'h0, 1'b0, 1'b1);
    cycle(1'b1, 2'd2, 16'h5A5A, 4'h0, 1'b0, 1'b1);
    chk("pre_reset_valid", 64'(out_valid), 64'h5);
    in_valid = 1'b0; clr = 1'b0; in_sel = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'h0);
    chk("async_out_data", out_data, 64'h0);
    chk("async_word_cnt", 64'(word_cnt), 64'h0);
    #2 rst_n = 1'b1;
    model_reset();
    #1;
    chk("post_reset_in_ready", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1;

    // Counter wrap: stream until 0xFFFE deliveries, then three more.
    guard = 0;
    while (m_cnt != 16'hFFFE && guard < 70000) begin
      cycle(1'b1, 2'(guard), 16'(guard), 4'hF, 1'b0, 1'b0);
      guard++;
    end
    chk("wrap_preload", 64'(word_cnt), 64'hFFFE);
    cycle(1'b1, 2'd1, 16'hC001, 4'hF, 1'b0, 1'b1);
    cycle(1'b0, 2'd1, 16'h0000, 4'hF, 1'b0, 1'b1);
    cycle(1'b1, 2'd2, 16'hC002, 4'hF, 1'b0, 1'b1);
    cycle(1'b0, 2'd2, 16'h0000, 4'hF, 1'b0, 1'b1);
    chk("wrap_cnt", 64'(word_cnt), 64'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
